// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding, default program-RAM depth
// and the opcode constants used by the rest of the CPU.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

  localparam int RAM_DEPTH_DEFAULT = 16;

  localparam logic [3:0] LDA = 4'b0001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] OUT = 4'b0011;

endpackage

// File: rtl/program_loader.sv
// Program loader: receives a byte stream (word count, data bytes and an
// optional checksum) and writes the data bytes into the program RAM while
// keeping the CPU halted. cpu_halt is released only after a good load.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state, the
// running checksum register and the error output; without it error is 0
// and no checksum byte is expected after the data.
module program_loader
  import cpu_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEFAULT,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cpu_halt,
  output logic              done,
  output logic              error
);

  loader_state_t state;
  loader_state_t state_next;

  // One extra bit so a full RAM_DEPTH load can be represented.
  logic [ADDR_W:0] word_count;
  logic [ADDR_W:0] byte_idx;
  logic [ADDR_W:0] byte_idx_inc;
  logic [ADDR_W:0] latched_n;
  logic            accept;
  logic            can_start;

  assign in_ready     = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign accept       = in_valid && in_ready;
  assign can_start    = (state == IDLE) || (state == DONE) || (state == ERR);
  assign byte_idx_inc = byte_idx + 1'b1;
  assign latched_n    = (in_data[ADDR_W-1:0] == '0) ? (ADDR_W+1)'(RAM_DEPTH)
                                                    : {1'b0, in_data[ADDR_W-1:0]};
  assign done         = (state == DONE);
  assign cpu_halt     = (state != DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  assign error = (state == ERR);
`else
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; start is only honoured outside an active load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = COUNT;
      end
      COUNT: begin
        if (accept) state_next = DATA;
      end
      DATA: begin
        if (accept && (byte_idx_inc == word_count)) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = (in_data == checksum) ? DONE : ERR;
      end
`endif
      default: state_next = state;
    endcase
  end

  // Word count, byte index and the registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      byte_idx   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      ram_we <= 1'b0;
      if (can_start && start) byte_idx <= '0;
      if ((state == COUNT) && accept) word_count <= latched_n;
      if ((state == DATA) && accept) begin
        byte_idx  <= byte_idx_inc;
        ram_we    <= 1'b1;
        ram_addr  <= byte_idx[ADDR_W-1:0];
        ram_wdata <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running 8-bit sum of the data bytes, carries discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (can_start && start) begin
      checksum <= '0;
    end else if ((state == DATA) && accept) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 16: number of program-RAM words written by one load.
REQ-002 SHALL have parameter ADDR_W, default 4: RAM address width, equal to log2(RAM_DEPTH).
REQ-003 SHALL have port clk, input, 1: the single clock; every flop samples on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a load.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a byte.
REQ-007 SHALL have port in_data, input, 8: byte stream carrying count, data bytes and checksum.
REQ-008 SHALL have port in_ready, output, 1: the loader accepts in_data this cycle.
REQ-009 SHALL have port ram_we, output, 1: program-RAM write strobe.
REQ-010 SHALL have port ram_addr, output, ADDR_W: program-RAM write address.
REQ-011 SHALL have port ram_wdata, output, 8: program-RAM write data.
REQ-012 SHALL have port cpu_halt, output, 1: holds the CPU step counter and PC frozen.
REQ-013 SHALL have port done, output, 1: the last load completed successfully.
REQ-014 SHALL have port error, output, 1: the last load failed its checksum.

Function
REQ-015 SHALL implement states IDLE, COUNT, DATA, CHECK, DONE, ERR.
REQ-016 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in COUNT, DATA and CHECK.
REQ-017 SHALL go from IDLE, DONE or ERR to COUNT on start=1, clearing done, error, the address counter and the checksum accumulator.
REQ-018 SHALL ignore start while in COUNT, DATA or CHECK.
REQ-019 SHALL, on the byte accepted in COUNT, latch N = in_data[ADDR_W-1:0] as the word count, with N=0 meaning RAM_DEPTH, and go to DATA.
REQ-020 SHALL, for each byte accepted in DATA, assert ram_we for exactly one cycle on the following cycle, with ram_wdata equal to that byte and ram_addr equal to its index (0, 1, ... N-1).
REQ-021 SHALL wrap the address counter modulo RAM_DEPTH, and SHALL never issue more than N writes per load.
REQ-022 SHALL accumulate checksum = sum of the accepted data bytes mod 256, in 8-bit arithmetic with carries discarded.
REQ-023 SHALL leave DATA after the N-th accepted byte, going to CHECK (macro defined) or DONE (macro undefined).
REQ-024 SHALL, on the byte accepted in CHECK, go to DONE if the byte equals the checksum, otherwise to ERR.
REQ-025 SHALL hold done=1 exactly in DONE and error=1 exactly in ERR.
REQ-026 SHALL drive cpu_halt=1 in every state except DONE; cpu_halt SHALL fall on the same cycle done rises.
REQ-027 SHALL register ram_we, ram_addr and ram_wdata; in_ready SHALL be decoded from state only.
REQ-028 SHALL, when in_valid=0 mid-load, hold state and counters indefinitely; there is no timeout.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE with in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_halt=1, done=0, error=0.
REQ-030 SHALL, on reset during a load, drop any pending write; RAM words already written SHALL remain unchanged.

Configuration
REQ-031 SHALL, with LOADER_CHECKSUM_EN defined, include the CHECK state, the accumulator and the error output behaviour above.
REQ-032 SHALL, with LOADER_CHECKSUM_EN undefined, omit CHECK and the accumulator, tie error to 0, and expect no checksum byte in the stream.

Structure
REQ-033 SHALL take the state enum, the RAM_DEPTH default and the CPU opcode constants (LDA=4'b0001, ADD=4'b0010, OUT=4'b0011) from shared package cpu_pkg.
REQ-034 SHALL be one module with no sub-modules; the accumulator is a single register.

Verification
REQ-035 SHALL cover: start, then bytes 0x03, 0x1F, 0x30, 0x2F, checksum 0x7E -> three writes at addresses 0,1,2 with data 1F,30,2F; then done=1, cpu_halt=0, error=0.
REQ-036 SHALL cover: as REQ-035 with checksum 0x7F -> the same three writes; then error=1, cpu_halt=1, done=0.
REQ-037 SHALL cover: count byte 0x00 followed by 16 bytes 0x01 and checksum 0x10 -> 16 writes at addresses 0..15; no 17th write; done=1.
REQ-038 SHALL cover: in_valid toggled 0/1 every other cycle through the REQ-035 stream -> results identical to REQ-035; no write without a prior handshake.
REQ-039 SHALL cover: rst pulsed after the second data byte -> IDLE, cpu_halt=1, no further ram_we; a fresh start then loads correctly.
REQ-040 SHALL cover: macro undefined, bytes 0x02, 0xAA, 0xBB -> two writes, then done=1 with no checksum byte consumed.
